// File: rtl/theta_sched_pkg.sv
// Shared types and widths for the theta ramp scheduler and its rate limiter.
package theta_sched_pkg;

  localparam int THETA_W = 32;
  localparam int ADC_W   = 14;

  localparam int DEF_THETA_INIT = 135;
  localparam int DEF_THETA_MIN  = 90;
  localparam int DEF_THETA_MAX  = 179;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } sched_state_t;

  // Saturate a requested angle into the permitted switching-surface window.
  function automatic logic signed [THETA_W-1:0] clamp_theta(
    input logic signed [THETA_W-1:0] value,
    input int                        lo,
    input int                        hi
  );
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/theta_rate_limiter.sv
// Step counter plus a 1-degree move toward the target every STEP_DIV cycles.
module theta_rate_limiter
  import theta_sched_pkg::*;
#(
  parameter int STEP_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  input  logic signed [THETA_W-1:0] load_value,
  input  logic signed [THETA_W-1:0] target,
  output logic signed [THETA_W-1:0] theta,
  output logic signed [THETA_W-1:0] theta_next
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_cnt_next;
  logic             wrap;

  assign wrap = (step_cnt == CNT_W'(STEP_DIV - 1));

  // theta_next is exposed so the parent can register flags against the new angle.
  always_comb begin
    step_cnt_next = step_cnt;
    theta_next    = theta;
    if (clear) begin
      step_cnt_next = '0;
      theta_next    = load_value;
    end else if (enable) begin
      step_cnt_next = wrap ? '0 : step_cnt + CNT_W'(1);
      if (wrap && (theta != target)) begin
        theta_next = (theta < target) ? theta + 1 : theta - 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
      theta    <= load_value;
    end else begin
      step_cnt <= step_cnt_next;
      theta    <= theta_next;
    end
  end

endmodule

// File: rtl/theta_ramp_scheduler.sv
// Start-up / run / over-current sequencer for the theta-based hybrid controller.
// Define THETA_SCHED_OCP_EN to build the over-current filter and FAULT state.
module theta_ramp_scheduler
  import theta_sched_pkg::*;
#(
  parameter int THETA_INIT = DEF_THETA_INIT,
  parameter int THETA_MIN  = DEF_THETA_MIN,
  parameter int THETA_MAX  = DEF_THETA_MAX,
  parameter int STEP_DIV   = 1000,
  parameter int I_LIMIT    = 7000,
  parameter int FAULT_FILT = 4,
  parameter int FAULT_HOLD = 50000
) (
  input  logic                      i_clock,
  input  logic                      i_RESET,
  input  logic                      i_enable,
  input  logic signed [THETA_W-1:0] i_theta_ref,
  input  logic signed [ADC_W-1:0]   i_iC,
  input  logic [3:0]                i_MOSFET,
  output logic signed [THETA_W-1:0] o_theta,
  output logic [3:0]                o_MOSFET,
  output logic [1:0]                o_state,
  output logic                      o_ready,
  output logic                      o_fault
);

  sched_state_t              state;
  sched_state_t              state_d;
  logic signed [THETA_W-1:0] tgt;
  logic signed [THETA_W-1:0] theta_next;
  logic                      tracking;
  logic                      tracking_d;
  logic                      step_enable;
  logic                      step_clear;
  logic                      trip;
  logic                      hold_done;

  assign tgt        = clamp_theta(i_theta_ref, THETA_MIN, THETA_MAX);
  assign tracking   = (state == ST_RAMP) || (state == ST_RUN);
  assign tracking_d = (state_d == ST_RAMP) || (state_d == ST_RUN);

  // The limiter only keeps its phase while staying inside RAMP/RUN; any entry or exit reloads it.
  assign step_enable = tracking && tracking_d;
  assign step_clear  = !step_enable;

`ifdef THETA_SCHED_OCP_EN
  localparam int AW1    = ADC_W + 1;
  localparam int FILT_W = (FAULT_FILT > 1) ? $clog2(FAULT_FILT + 1) : 1;
  localparam int HOLD_W = (FAULT_HOLD > 0) ? $clog2(FAULT_HOLD + 1) : 1;

  logic signed [ADC_W:0] ic_ext;
  logic [ADC_W:0]        abs_ic;
  logic                  over_limit;
  logic [FILT_W-1:0]     filt_cnt;
  logic [HOLD_W-1:0]     hold_cnt;

  // One extra bit so the most negative sample has a representable magnitude.
  assign ic_ext     = {i_iC[ADC_W-1], i_iC};
  assign abs_ic     = ic_ext[ADC_W] ? $unsigned(-ic_ext) : $unsigned(ic_ext);
  assign over_limit = abs_ic > AW1'(I_LIMIT);
  assign trip       = tracking && over_limit && (filt_cnt == FILT_W'(FAULT_FILT - 1));
  assign hold_done  = (hold_cnt == HOLD_W'(FAULT_HOLD));

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      filt_cnt <= '0;
    end else if (step_enable && over_limit) begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end else begin
      filt_cnt <= '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_RESET || (state != ST_FAULT)) begin
      hold_cnt <= '0;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign o_fault = (state == ST_FAULT);
`else
  logic unused_ocp;

  assign unused_ocp = ^{i_iC, 32'(I_LIMIT), 32'(FAULT_FILT), 32'(FAULT_HOLD)};
  assign trip       = 1'b0;
  assign hold_done  = 1'b1;
  assign o_fault    = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Fault trip outranks a dropped enable, which outranks the RAMP->RUN hand-off.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (i_enable) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (trip)                state_d = ST_FAULT;
        else if (!i_enable)      state_d = ST_IDLE;
        else if (o_theta == tgt) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trip)           state_d = ST_FAULT;
        else if (!i_enable) state_d = ST_IDLE;
      end
      ST_FAULT: begin
`ifdef THETA_SCHED_OCP_EN
        if (hold_done && !i_enable) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  theta_rate_limiter #(
    .STEP_DIV (STEP_DIV)
  ) u_limiter (
    .clk        (i_clock),
    .rst        (i_RESET),
    .enable     (step_enable),
    .clear      (step_clear),
    .load_value (THETA_W'(THETA_INIT)),
    .target     (tgt),
    .theta      (o_theta),
    .theta_next (theta_next)
  );

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      o_ready <= 1'b0;
    end else begin
      o_ready <= (state_d == ST_RUN) && (theta_next == tgt);
    end
  end

  assign o_state  = state;
  assign o_MOSFET = tracking ? i_MOSFET : 4'd0;

endmodule

// File: tb/tb_theta_ramp_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_theta_ramp_scheduler;

  localparam int THETA_INIT = 135;
  localparam int THETA_MIN  = 90;
  localparam int THETA_MAX  = 179;
  localparam int STEP_DIV   = 4;
  localparam int I_LIMIT    = 7000;
  localparam int FAULT_FILT = 4;
  localparam int FAULT_HOLD = 10;
`ifdef THETA_SCHED_OCP_EN
  localparam bit OCP = 1'b1;
`else
  localparam bit OCP = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               rst;
  logic               en;
  logic signed [31:0] theta_ref;
  logic signed [13:0] ic;
  logic [3:0]         mos;
  logic signed [31:0] theta;
  logic [3:0]         mos_out;
  logic [1:0]         state;
  logic               ready;
  logic               fault;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_on       = 1'b0;
  int burst_left   = 0;

  int m_state = 0;
  int m_theta = THETA_INIT;
  int m_ticks = 0;
  int m_over  = 0;
  int m_fc    = 0;
  int m_ready = 0;

  theta_ramp_scheduler #(
    .THETA_INIT (THETA_INIT),
    .THETA_MIN  (THETA_MIN),
    .THETA_MAX  (THETA_MAX),
    .STEP_DIV   (STEP_DIV),
    .I_LIMIT    (I_LIMIT),
    .FAULT_FILT (FAULT_FILT),
    .FAULT_HOLD (FAULT_HOLD)
  ) dut (
    .i_clock     (clock),
    .i_RESET     (rst),
    .i_enable    (en),
    .i_theta_ref (theta_ref),
    .i_iC        (ic),
    .i_MOSFET    (mos),
    .o_theta     (theta),
    .o_MOSFET    (mos_out),
    .o_state     (state),
    .o_ready     (ready),
    .o_fault     (fault)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Behavioural reference: one call per clock edge, rules applied directly on integers.
  task automatic modelStep();
    int  tgt;
    int  mag;
    bit  over;
    tgt  = int'(theta_ref);
    if (tgt < THETA_MIN) tgt = THETA_MIN;
    if (tgt > THETA_MAX) tgt = THETA_MAX;
    mag  = int'(ic);
    if (mag < 0) mag = -mag;
    over = (mag > I_LIMIT);
    if (rst) begin
      m_state = 0; m_theta = THETA_INIT; m_ticks = 0; m_over = 0; m_fc = 0; m_ready = 0;
      return;
    end
    case (m_state)
      0: if (en) begin
        m_state = 1; m_theta = THETA_INIT; m_ticks = 0; m_over = 0;
      end
      1, 2: begin
        if (OCP && over && (m_over + 1 >= FAULT_FILT)) begin
          m_state = 3; m_theta = THETA_INIT; m_fc = 0; m_over = 0;
        end else if (!en) begin
          m_state = 0; m_theta = THETA_INIT; m_over = 0;
        end else begin
          m_over = over ? m_over + 1 : 0;
          if (m_state == 1 && m_theta == tgt) m_state = 2;
          m_ticks++;
          if ((m_ticks % STEP_DIV) == 0 && m_theta != tgt)
            m_theta += (tgt > m_theta) ? 1 : -1;
        end
      end
      default: begin
        m_fc++;
        if (m_fc > FAULT_HOLD && !en) m_state = 0;
      end
    endcase
    m_ready = (m_state == 2 && m_theta == tgt) ? 1 : 0;
  endtask

  always @(posedge clock) modelStep();

  always @(negedge clock) begin
    if (chk_on) begin
      checkOutput("model_state", 32'(state), 32'(m_state));
      checkOutput("model_theta", theta, 32'(m_theta));
      checkOutput("model_mosfet", 32'(mos_out), (m_state == 1 || m_state == 2) ? 32'(mos) : 32'd0);
      checkOutput("model_ready", 32'(ready), 32'(m_ready));
      checkOutput("model_fault", 32'(fault), (m_state == 3) ? 32'd1 : 32'd0);
    end
  end

  task automatic applyStimulus();
    int v;
    rst = ($urandom_range(0, 299) == 0);
    if ($urandom_range(0, 49) == 0) en = ~en;
    if ($urandom_range(0, 99) == 0) theta_ref = $signed(32'($urandom_range(0, 260))) - 40;
    if (burst_left > 0) begin
      burst_left--;
      case ($urandom_range(0, 5))
        0: ic = 14'sd7001;
        1: ic = -14'sd7001;
        2: ic = 14'sd8191;
        3: ic = -14'sd8192;
        4: ic = 14'sd7000;
        default: ic = -14'sd7000;
      endcase
    end else begin
      if ($urandom_range(0, 39) == 0) burst_left = $urandom_range(1, 6);
      v  = int'($urandom_range(0, 14000)) - 7000;
      ic = 14'(v);
    end
    mos = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; theta_ref = 140; ic = '0; mos = 4'hF;
    advance(2);
    rst = 1'b0;
    chk_on = 1'b1;
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_theta", theta, 32'd135);
    checkOutput("reset_mosfet", 32'(mos_out), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);

    // Ramp 135 -> 140 with enable raised in cycle 0.
    mos = 4'hA;
    en  = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      advance(1);
      if (c == 1) checkOutput("ramp_entry", 32'(state), 32'd1);
      if (c == 2) checkOutput("ramp_mosfet", 32'(mos_out), 32'hA);
      if (c == 4) checkOutput("ramp_no_early_step", theta, 32'd135);
      if (c >= 5 && ((c - 5) % 4) == 0) checkOutput("ramp_step", theta, 32'(136 + (c - 5) / 4));
      if (c == 21) checkOutput("ramp_before_run", 32'(state), 32'd1);
    end
    checkOutput("run_state", 32'(state), 32'd2);
    checkOutput("run_ready", 32'(ready), 32'd1);

    // Clamping at both ends of the window.
    theta_ref = 200;
    for (int k = 0; k < 400 && theta != 179; k++) advance(1);
    advance(20);
    checkOutput("clamp_high", theta, 32'd179);
    checkOutput("clamp_high_ready", 32'(ready), 32'd1);
    theta_ref = 10;
    for (int k = 0; k < 500 && theta != 90; k++) advance(1);
    advance(20);
    checkOutput("clamp_low", theta, 32'd90);

    // Abort mid-ramp by dropping enable, then by reset.
    en = 1'b0;
    advance(1);
    checkOutput("disable_idle", 32'(state), 32'd0);
    theta_ref = 140;
    en = 1'b1;
    for (int k = 0; k < 100 && theta != 137; k++) advance(1);
    checkOutput("abort_reach_137", theta, 32'd137);
    en = 1'b0;
    advance(1);
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_theta", theta, 32'd135);
    checkOutput("abort_mosfet", 32'(mos_out), 32'd0);
    en = 1'b1;
    for (int k = 0; k < 100 && theta != 137; k++) advance(1);
    checkOutput("rst_reach_137", theta, 32'd137);
    rst = 1'b1;
    advance(1);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_theta", theta, 32'd135);
    checkOutput("rst_mosfet", 32'(mos_out), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    en  = 1'b0;
    advance(2);

`ifdef THETA_SCHED_OCP_EN
    // Filter: three over-limit samples then one at the limit must not trip.
    theta_ref = 170;
    mos = 4'h5;
    en  = 1'b1;
    advance(10);
    ic = 14'sd7001;
    advance(3);
    ic = 14'sd7000;
    advance(1);
    checkOutput("filt_no_trip_state", 32'(state), 32'd1);
    checkOutput("filt_no_trip_fault", 32'(fault), 32'd0);
    ic = -14'sd7001;
    advance(3);
    checkOutput("filt_three_state", 32'(state), 32'd1);
    advance(1);
    checkOutput("trip_state", 32'(state), 32'd3);
    checkOutput("trip_mosfet", 32'(mos_out), 32'd0);
    checkOutput("trip_fault", 32'(fault), 32'd1);
    checkOutput("trip_theta", theta, 32'd135);
    ic = '0;
    advance(40);
    checkOutput("fault_held_by_enable", 32'(state), 32'd3);
    en = 1'b0;
    advance(1);
    checkOutput("fault_release", 32'(state), 32'd0);
    // Enable dropped five cycles into FAULT: exit once the hold expires.
    en = 1'b1;
    advance(10);
    ic = -14'sd7001;
    advance(4);
    checkOutput("trip2_state", 32'(state), 32'd3);
    ic = '0;
    advance(5);
    en = 1'b0;
    advance(5);
    checkOutput("hold_not_expired", 32'(state), 32'd3);
    advance(1);
    checkOutput("hold_expired_idle", 32'(state), 32'd0);
`else
    // Without over-current protection a full-scale negative current is ignored.
    ic = -14'sd8192;
    theta_ref = 140;
    en = 1'b1;
    for (int k = 0; k < 100 && state != 2'd2; k++) advance(1);
    checkOutput("noocp_run", 32'(state), 32'd2);
    checkOutput("noocp_theta", theta, 32'd140);
    checkOutput("noocp_fault", 32'(fault), 32'd0);
    en = 1'b0;
    ic = '0;
`endif
    advance(2);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      advance(1);
    end
    rst = 1'b0;
    advance(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/theta_ramp_scheduler.md
# theta_ramp_scheduler

Sequences the resonant-converter hybrid controller through start-up, steady run and over-current shutdown. Drives the switching-surface angle into the theta-based hybrid controller with a rate-limited soft ramp. Gates that controller's MOSFET commands so no switching occurs outside the ramp and run states. Sits between the top-level command logic and the hybrid controller.

## Interface
- THETA_INIT, 135: angle, in integer degrees, driven in IDLE and FAULT and used as the ramp start.
- THETA_MIN, 90: lower clamp applied to the target angle.
- THETA_MAX, 179: upper clamp applied to the target angle.
- STEP_DIV, 1000: clock cycles per 1-degree step of o_theta; must be ≥ 1.
- I_LIMIT, 7000: over-current threshold on |i_iC|, in 14-bit ADC counts.
- FAULT_FILT, 4: number of consecutive over-limit samples that trip a fault; must be ≥ 1.
- FAULT_HOLD, 50000: minimum number of cycles spent in FAULT.

Ports:
- i_clock  in  1  system clock
- i_RESET  in  1  synchronous, active-high reset
- i_enable  in  1  run request (level)
- i_theta_ref  in  32 signed  target angle, integer degrees
- i_iC  in  14 signed  tank current sample
- i_MOSFET  in  4  gate command from the hybrid controller
- o_theta  out  32 signed  angle to the hybrid controller
- o_MOSFET  out  4  gated gate command to the power stage
- o_state  out  2  current state: IDLE=0, RAMP=1, RUN=2, FAULT=3
- o_ready  out  1  high in RUN when o_theta equals the clamped target
- o_fault  out  1  high while in FAULT

## Operation
- The target is tgt = clamp(i_theta_ref, THETA_MIN, THETA_MAX), evaluated combinationally every cycle.
- IDLE:
  - o_theta = THETA_INIT, o_MOSFET = 0.
  - i_enable = 1 → RAMP.
- RAMP:
  - o_MOSFET = i_MOSFET.
  - The step counter runs 0..STEP_DIV-1 and wraps.
  - At wrap, if o_theta ≠ tgt, o_theta moves ±1 toward tgt.
  - When o_theta == tgt → RUN.
- RUN:
  - Same rate-limited tracking as RAMP; o_MOSFET = i_MOSFET.
  - o_ready = (o_theta == tgt).
  - A changed target is tracked at 1 degree per STEP_DIV cycles and never jumps.
- Over-current (RAMP/RUN only):
  - |i_iC| is computed at 15 bits, so -8192 gives 8192 with no overflow.
  - The filter counter increments while |i_iC| > I_LIMIT and clears on any sample ≤ I_LIMIT. Equal to the limit does not count.
  - When the counter reaches FAULT_FILT → FAULT.
- FAULT:
  - o_MOSFET = 0, o_theta = THETA_INIT, o_fault = 1.
  - The hold counter counts to FAULT_HOLD.
  - Exit to IDLE only when the hold has expired AND i_enable == 0. Otherwise stay in FAULT.
- i_enable = 0 in RAMP or RUN → IDLE next cycle, and o_theta returns to THETA_INIT.
- Priority in a single cycle: reset > fault trip > i_enable = 0 > RAMP→RUN.
- Entering RAMP clears both the step counter and the filter counter. Entering FAULT clears the hold counter.

## Timing
- State, o_theta, the counters and o_ready are registered.
- o_MOSFET is combinational from the registered state and i_MOSFET, so it adds zero latency to the gate path.
- o_MOSFET is forced to 0 in the same cycle o_state becomes FAULT.
- i_RESET at a clock edge gives, on the next cycle:
  - state IDLE, o_theta = THETA_INIT, o_MOSFET = 0
  - o_ready = 0, o_fault = 0, all counters 0
- Reset mid-ramp aborts immediately with no further theta steps.
- First theta step: STEP_DIV cycles after the RAMP entry edge.
- RAMP→RUN: one cycle after the step that makes o_theta == tgt.
- If tgt == THETA_INIT at entry, RUN follows one cycle after RAMP with no steps.
- Fault trip: state becomes FAULT on the edge after the FAULT_FILT-th consecutive over-limit sample.

## Configuration
- THETA_SCHED_OCP_EN defined: over-current filter and FAULT state are implemented as described.
- THETA_SCHED_OCP_EN undefined:
  - The filter and hold counters are removed.
  - FAULT is unreachable, o_fault is tied to 0, and i_iC is unused.
  - o_state never reports 3.

## Structure
- Shared package theta_sched_pkg holds:
  - the state encoding constants
  - the theta width (32)
  - the ADC width (14)
  - default angle limits
- One sub-module, theta_rate_limiter, implements the step counter plus the ±1 move toward the target.
  - Inputs: enable, clear, load value, target.
  - Output: the current angle.

## Test plan
- Parameters STEP_DIV=4, THETA_INIT=135, ref=140, enable at cycle 0:
  - RAMP at cycle 1.
  - o_theta steps 136..140 at cycles 5, 9, 13, 17, 21.
  - RUN and o_ready=1 at cycle 22.
- Clamping:
  - ref=200 → o_theta ramps to 179 and stops.
  - ref=10 → o_theta ramps down to 90.
- Over-current filter, with FAULT_FILT=4 and I_LIMIT=7000:
  - 3 samples of 7001 followed by 1 sample of 7000 → no fault.
  - 4 samples of -7001 → FAULT on the next edge, o_MOSFET=0 in that cycle, o_fault=1.
- Fault exit, with FAULT_HOLD=10:
  - i_enable held at 1 → remains in FAULT indefinitely.
  - i_enable dropped at cycle 5 of FAULT → IDLE after the hold expires.
- Abort and reset:
  - i_enable=0 mid-ramp at o_theta=137 → IDLE, o_theta=135, o_MOSFET=0 next cycle.
  - Repeat with i_RESET → same result, with all outputs at their reset values.
- Build with THETA_SCHED_OCP_EN undefined and i_iC=-8192 held → no fault, ramp completes normally.
